regf_wb_ctrl: RTL and testbench

//  Write-back controller that owns the single write port of the 32x32 register

---
 rtl/regf_wb_ctrl_if.sv | 36 +++
 rtl/regf_wb_ctrl.sv | 145 ++++++++++++++
 tb/tb_regf_wb_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/regf_wb_ctrl_if.sv
// Write-back bus: ALU and load result handshakes in, register-file write port
// and load-queue status out.
interface regf_wb_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int LD_DEPTH      = 4
);
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
  localparam int CNT_W    = $clog2(LD_DEPTH) + 1;

  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDRESS_WIDTH-1:0] alu_dest;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [ADDRESS_WIDTH-1:0] ld_dest;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     rg_wrt_en;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
  logic [DATA_WIDTH-1:0]    rg_wrt_data;
  logic [NUM_REGS-1:0]      pend_mask;
  logic [CNT_W-1:0]         ld_count;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
    input  alu_ready, ld_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data,
           pend_mask, ld_count
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
    output alu_ready, ld_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data,
           pend_mask, ld_count
  );
endinterface

// File: rtl/regf_wb_ctrl.sv
// Register-file write-back arbiter: ALU results win, loads queue in a small FIFO
// whose entries are killed by younger ALU writes to the same register.
module regf_wb_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int LD_DEPTH      = 4,
  parameter int STARVE_MAX    = 8,
  parameter int ZERO_REG      = 1
) (
  input logic           clk,
  input logic           rst,
  regf_wb_ctrl_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
  localparam int PTR_W    = $clog2(LD_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STV_W    = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_LIM  = CNT_W'(LD_DEPTH);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [STV_W-1:0]         starve_q, starve_d;
  logic [LD_DEPTH-1:0]      live_q, live_d;
  logic [ADDRESS_WIDTH-1:0] fdest_q [LD_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fdest_d [LD_DEPTH];
  logic [DATA_WIDTH-1:0]    fdata_q [LD_DEPTH];
  logic [DATA_WIDTH-1:0]    fdata_d [LD_DEPTH];
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]      pend_q, pend_d;

  logic alu_ready, ld_ready, alu_xfer, alu_issue, ld_xfer;
  logic head_busy, head_live, pop, ld_issue, ld_born_dead;

  assign alu_ready = !rst && (starve_q < STARVE_LIM);
  assign ld_ready  = !rst && (count_q < DEPTH_LIM);
  assign alu_xfer  = bus.alu_valid && alu_ready;
  // A zero-register ALU result is accepted but frees the port for the FIFO.
  assign alu_issue = alu_xfer && !((ZERO_REG != 0) && (bus.alu_dest == '0));
  assign ld_xfer   = bus.ld_valid && ld_ready;
  assign head_busy = (count_q != '0);
  assign head_live = live_q[head_q];
  assign pop       = !alu_issue && head_busy;
  assign ld_issue  = pop && head_live;
  assign ld_born_dead = (alu_issue && (bus.ld_dest == bus.alu_dest)) ||
                        ((ZERO_REG != 0) && (bus.ld_dest == '0));

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    starve_d  = starve_q;
    live_d    = live_q;
    fdest_d   = fdest_q;
    fdata_d   = fdata_q;
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;

    // Younger ALU write supersedes any queued load to the same register.
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (alu_issue && (fdest_q[i] == bus.alu_dest)) live_d[i] = 1'b0;
    end

    if (alu_issue) begin
      wr_en_d   = 1'b1;
      wr_dest_d = bus.alu_dest;
      wr_data_d = bus.alu_data;
    end else if (ld_issue) begin
      wr_en_d   = 1'b1;
      wr_dest_d = fdest_q[head_q];
      wr_data_d = fdata_q[head_q];
    end

    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end

    if (ld_xfer) begin
      fdest_d[tail_q] = bus.ld_dest;
      fdata_d[tail_q] = bus.ld_data;
      live_d[tail_q]  = !ld_born_dead;
      tail_d          = tail_q + PTR_W'(1);
    end

    case ({ld_xfer, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (ld_issue || !head_busy) starve_d = '0;
    else if (alu_issue && head_live) starve_d = starve_q + STV_W'(1);
  end

  // Pending mask is built from the post-edge FIFO so it lines up with ld_count.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
    logic [LD_DEPTH-1:0] hit;
    for (genvar gj = 0; gj < LD_DEPTH; gj++) begin : g_slot
      assign hit[gj] = live_d[gj] && (fdest_d[gj] == ADDRESS_WIDTH'(gi));
    end
    assign pend_d[gi] = |hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      live_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      pend_q    <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      live_q    <= live_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
    end
  end

  // Payload storage carries no reset; live_q alone decides what is meaningful.
  always_ff @(posedge clk) begin
    fdest_q <= fdest_d;
    fdata_q <= fdata_d;
  end

  assign bus.alu_ready   = alu_ready;
  assign bus.ld_ready    = ld_ready;
  assign bus.rg_wrt_en   = wr_en_q;
  assign bus.rg_wrt_dest = wr_dest_q;
  assign bus.rg_wrt_data = wr_data_q;
  assign bus.pend_mask   = pend_q;
  assign bus.ld_count    = count_q;
endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Scoreboarded bench for regf_wb_ctrl: expected register writes are queued as
// stimulus is driven and matched against rg_wrt_* on every negedge.
module tb_regf_wb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regf_wb_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .LD_DEPTH(4)) bus ();

  regf_wb_ctrl #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .LD_DEPTH(4), .STARVE_MAX(8), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [4:0] dest, input logic [31:0] data);
    exp_q.push_back({dest, data});
  endtask

  // Write monitor: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rg_wrt_en === 1'b1) begin
      $display("wr dest=%0d data=%08h", bus.rg_wrt_dest, bus.rg_wrt_data);
      if (exp_q.size() == 0) begin
        chk("unexp_wr", exp_q.size(), 1);
      end else begin
        chk("wr", {bus.rg_wrt_dest, bus.rg_wrt_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issues;
    bus.alu_valid = 0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.ld_valid  = 0; bus.ld_dest  = '0; bus.ld_data  = '0;

    // Reset state
    step(); step();
    chk("rst_wr_en", bus.rg_wrt_en, 0);
    chk("rst_wr_dest", bus.rg_wrt_dest, 0);
    chk("rst_wr_data", bus.rg_wrt_data, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_count", bus.ld_count, 0);
    chk("rst_alu_rdy", bus.alu_ready, 0);
    chk("rst_ld_rdy", bus.ld_ready, 0);
    rst = 0;
    step();

    // T1: ALU alone, then output holds dest/data with enable low
    bus.alu_valid = 1; bus.alu_dest = 5; bus.alu_data = 32'hDEADBEEF;
    exp_push(5, 32'hDEADBEEF);
    step();
    bus.alu_valid = 0;
    chk("t1_en", bus.rg_wrt_en, 1);
    step();
    chk("t1_hold_en", bus.rg_wrt_en, 0);
    chk("t1_hold_dest", bus.rg_wrt_dest, 5);
    chk("t1_hold_data", bus.rg_wrt_data, 32'hDEADBEEF);

    // T2: load alone, two-cycle latency
    bus.ld_valid = 1; bus.ld_dest = 7; bus.ld_data = 32'h12;
    exp_push(7, 32'h12);
    step();
    bus.ld_valid = 0;
    chk("t2_pend", bus.pend_mask, 32'h80);
    chk("t2_count", bus.ld_count, 1);
    chk("t2_no_bypass", bus.rg_wrt_en, 0);
    step();
    chk("t2_pend_clr", bus.pend_mask, 0);
    chk("t2_count_clr", bus.ld_count, 0);

    // T3: fill the FIFO while the ALU owns the port
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1; bus.alu_dest = 5'(10 + k); bus.alu_data = 32'h100 + k;
      bus.ld_valid  = 1; bus.ld_dest  = 5'(20 + k); bus.ld_data  = 32'h200 + k;
      exp_push(5'(10 + k), 32'h100 + k);
      step();
    end
    chk("t3_full_count", bus.ld_count, 4);
    chk("t3_full_rdy", bus.ld_ready, 0);
    bus.alu_dest = 14; bus.alu_data = 32'h104;
    bus.ld_dest = 24; bus.ld_data = 32'h204;
    exp_push(14, 32'h104);
    step();
    chk("t3_stall_count", bus.ld_count, 4);
    bus.alu_valid = 0;
    for (int k = 0; k < 5; k++) exp_push(5'(20 + k), 32'h200 + k);
    step();
    chk("t3_rdy_after_pop", bus.ld_ready, 1);
    step();
    bus.ld_valid = 0;
    chk("t3_count_steady", bus.ld_count, 3);
    for (int i = 0; i < 12 && bus.ld_count != 0; i++) step();
    chk("t3_drain", bus.ld_count, 0);
    step();

    // T4: ALU kills a queued load; then same-cycle load/ALU to one dest
    bus.ld_valid = 1; bus.ld_dest = 3; bus.ld_data = 32'h33;
    step();
    bus.ld_valid = 0;
    chk("t4_pend", bus.pend_mask, 32'h8);
    bus.alu_valid = 1; bus.alu_dest = 3; bus.alu_data = 32'hA;
    exp_push(3, 32'hA);
    step();
    bus.alu_valid = 0;
    chk("t4_kill_pend", bus.pend_mask, 0);
    chk("t4_slot_kept", bus.ld_count, 1);
    step();
    chk("t4_popped", bus.ld_count, 0);
    bus.alu_valid = 1; bus.alu_dest = 9; bus.alu_data = 32'h99;
    bus.ld_valid  = 1; bus.ld_dest  = 9; bus.ld_data  = 32'h98;
    exp_push(9, 32'h99);
    step();
    bus.alu_valid = 0; bus.ld_valid = 0;
    chk("t4_same_pend", bus.pend_mask, 0);
    chk("t4_same_count", bus.ld_count, 1);
    step();
    chk("t4_same_popped", bus.ld_count, 0);
    step();

    // T5: starvation throttle
    bus.ld_valid = 1; bus.ld_dest = 15; bus.ld_data = 32'h515;
    step();
    bus.ld_valid = 0;
    issues = 0;
    bus.alu_valid = 1;
    while (bus.alu_ready && issues < 20) begin
      bus.alu_dest = 5'(16 + issues); bus.alu_data = 32'h5000 + issues;
      exp_push(5'(16 + issues), 32'h5000 + issues);
      step();
      issues++;
    end
    chk("t5_issues", issues, 8);
    exp_push(15, 32'h515);
    step();
    chk("t5_rdy_back", bus.alu_ready, 1);
    chk("t5_count", bus.ld_count, 0);
    bus.alu_valid = 0;
    step();

    // T6: reset discards queued loads; zero-register writes vanish
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1; bus.alu_dest = 5'(25 + k); bus.alu_data = 32'h600 + k;
      bus.ld_valid = 1; bus.ld_data = 32'h700 + k;
      bus.ld_dest = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
      exp_push(5'(25 + k), 32'h600 + k);
      step();
    end
    bus.alu_valid = 0; bus.ld_valid = 0;
    chk("t6_pend_pre", bus.pend_mask, 32'h16);
    chk("t6_count_pre", bus.ld_count, 3);
    rst = 1;
    step();
    chk("t6_rst_pend", bus.pend_mask, 0);
    chk("t6_rst_count", bus.ld_count, 0);
    chk("t6_rst_en", bus.rg_wrt_en, 0);
    step();
    rst = 0;
    step(); step(); step();
    chk("t6_quiet", bus.rg_wrt_en, 0);
    bus.alu_valid = 1; bus.alu_dest = 0; bus.alu_data = 32'hBAD;
    step();
    bus.alu_valid = 0;
    chk("t6_zero_alu", bus.rg_wrt_en, 0);
    bus.ld_valid = 1; bus.ld_dest = 0; bus.ld_data = 32'hBAD0;
    step();
    bus.ld_valid = 0;
    chk("t6_zero_ld_pend", bus.pend_mask, 0);
    chk("t6_zero_ld_count", bus.ld_count, 1);
    step();
    chk("t6_zero_ld_pop", bus.ld_count, 0);
    step(); step();

    chk("sb_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
